// File: rtl/strobe_hold.sv
// Turns single-cycle event strobes into a held, acknowledged level flag with a
// per-event toggle line and a saturating queue of events still to present.
module strobe_hold #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned COUNT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in,
  input  logic                   ack,
  output logic                   out,
  output logic                   toggle,
  output logic [COUNT_WIDTH-1:0] pending,
  output logic                   overflow
);

  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] PEND_MAX = {COUNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    WAIT_ACK = 2'd2,
    GAP      = 2'd3
  } state_t;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_ack_lat;
  logic [COUNT_WIDTH-1:0] r_pending;
  logic                   r_overflow;
  logic                   r_toggle;
  logic                   r_out;

  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_ack_lat_nxt;
  logic [COUNT_WIDTH-1:0] w_pending_nxt;
  logic                   w_overflow_nxt;
  logic                   w_toggle_nxt;
  logic                   w_out_nxt;
  logic                   w_release;
  logic                   w_inc;
  logic                   w_dec;
  logic                   w_lost;

  // Next-state, queue accounting and output decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_ack_lat_nxt  = r_ack_lat;
    w_pending_nxt  = r_pending;
    w_overflow_nxt = r_overflow;
    w_toggle_nxt   = r_toggle;
    w_release      = 1'b0;
    w_inc          = 1'b0;
    w_dec          = 1'b0;
    w_lost         = 1'b0;

    case (r_state)
      IDLE: begin
        if (in) begin
          w_state_nxt   = HOLD;
          w_cnt_nxt     = CNT_LOAD;
          w_ack_lat_nxt = 1'b0;
        end
      end
      HOLD: begin
        if (r_cnt == '0) begin
          if (ack || r_ack_lat) w_release = 1'b1;
          else                  w_state_nxt = WAIT_ACK;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
          if (ack) w_ack_lat_nxt = 1'b1;
        end
      end
      WAIT_ACK: begin
        if (ack) w_release = 1'b1;
      end
      GAP: begin
        w_state_nxt   = HOLD;
        w_cnt_nxt     = CNT_LOAD;
        w_ack_lat_nxt = 1'b0;
      end
      default: w_state_nxt = IDLE;
    endcase

    // An event coinciding with a release to an empty queue is queued and
    // immediately dequeued, so it still earns its own GAP.
    w_inc = in && (r_state != IDLE);
    if (w_release) begin
      if ((r_pending != '0) || in) begin
        w_state_nxt = GAP;
        w_dec       = 1'b1;
      end else begin
        w_state_nxt = IDLE;
      end
    end

    w_lost = w_inc && !w_dec && (r_pending == PEND_MAX);
    if (w_inc && !w_dec && !w_lost) w_pending_nxt = r_pending + COUNT_WIDTH'(1);
    else if (w_dec && !w_inc)       w_pending_nxt = r_pending - COUNT_WIDTH'(1);

    if (w_lost) w_overflow_nxt = 1'b1;
    if (in && !w_lost) w_toggle_nxt = ~r_toggle;

    w_out_nxt = (w_state_nxt == HOLD) || (w_state_nxt == WAIT_ACK);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_ack_lat  <= 1'b0;
      r_pending  <= '0;
      r_overflow <= 1'b0;
      r_toggle   <= 1'b0;
      r_out      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ack_lat  <= w_ack_lat_nxt;
      r_pending  <= w_pending_nxt;
      r_overflow <= w_overflow_nxt;
      r_toggle   <= w_toggle_nxt;
      r_out      <= w_out_nxt;
    end
  end

  assign out      = r_out;
  assign toggle   = r_toggle;
  assign pending  = r_pending;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_strobe_hold.sv
// Scoreboard bench for strobe_hold: directed stimulus pushes hand-computed
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_strobe_hold;

  localparam int unsigned HOLD_CYCLES = 4;
  localparam int unsigned COUNT_WIDTH = 2;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   in = 1'b0;
  logic                   ack = 1'b0;
  logic                   out;
  logic                   toggle;
  logic [COUNT_WIDTH-1:0] pending;
  logic                   overflow;

  typedef struct {
    int                     cyc;
    string                  name;
    logic                   o;
    logic                   t;
    logic [COUNT_WIDTH-1:0] p;
    logic                   v;
  } exp_t;

  exp_t  sb[$];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_err = 0;
  string tag = "reset";

  strobe_hold #(.HOLD_CYCLES(HOLD_CYCLES), .COUNT_WIDTH(COUNT_WIDTH)) dut (
    .clk(clk), .reset(reset), .in(in), .ack(ack),
    .out(out), .toggle(toggle), .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expectation for the cycle after the current one (registered response).
  task automatic chk(input logic o, input logic t, input int p, input logic v);
    exp_t e;
    e.cyc = cyc + 1; e.name = tag; e.o = o; e.t = t;
    e.p = COUNT_WIDTH'(p); e.v = v;
    sb.push_back(e);
  endtask

  task automatic step(input logic r, input logic i, input logic a);
    reset = r; in = i; ack = a;
    @(posedge clk); #1;
    reset = 1'b0; in = 1'b0; ack = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compares DUT outputs against the queued expectation for this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      if (e.cyc != cyc) begin
        n_err++;
        $display("FAIL %s: expectation for cycle %0d checked late at cycle %0d", e.name, e.cyc, cyc);
      end else if (out !== e.o || toggle !== e.t || pending !== e.p || overflow !== e.v) begin
        n_err++;
        $display("FAIL %s cyc %0d: got out=%b toggle=%b pending=%0d overflow=%b, want out=%b toggle=%b pending=%0d overflow=%b",
                 e.name, cyc, out, toggle, pending, overflow, e.o, e.t, e.p, e.v);
      end
    end
  end

  initial begin
    @(posedge clk); #1;

    // Reset state; in/ack ignored while reset is high.
    tag = "reset";
    chk(0, 0, 0, 0); step(1, 1, 1);
    chk(0, 0, 0, 0); step(1, 1, 0);
    chk(0, 0, 0, 0); step(0, 0, 0);

    // Single event, no ack, then late ack.
    tag = "single";
    chk(1, 1, 0, 0); step(0, 1, 0);
    chk(1, 1, 0, 0); step(0, 0, 0);
    idle(1);
    chk(1, 1, 0, 0); step(0, 0, 0);
    tag = "wait_ack";
    chk(1, 1, 0, 0); step(0, 0, 0);
    idle(3);
    chk(1, 1, 0, 0); step(0, 0, 0);
    tag = "late_ack";
    chk(0, 1, 0, 0); step(0, 0, 1);
    chk(0, 1, 0, 0); step(0, 0, 0);

    // Early ack is latched; release after the minimum hold.
    tag = "early_ack";
    chk(1, 0, 0, 0); step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    chk(1, 0, 0, 0); step(0, 0, 0);
    chk(0, 0, 0, 0); step(0, 0, 0);
    chk(0, 0, 0, 0); step(0, 0, 0);

    // Ack on the last hold cycle.
    tag = "edge_ack";
    chk(1, 1, 0, 0); step(0, 1, 0);
    idle(2);
    chk(1, 1, 0, 0); step(0, 0, 0);
    chk(0, 1, 0, 0); step(0, 0, 1);
    step(0, 0, 0);

    // Queuing, gap, simultaneous event with release.
    tag = "queue";
    chk(1, 0, 0, 0); step(0, 1, 0);
    step(0, 0, 0);
    chk(1, 1, 1, 0); step(0, 1, 0);
    chk(1, 0, 2, 0); step(0, 1, 0);
    idle(6);
    tag = "gap1";
    chk(0, 0, 1, 0); step(0, 0, 1);
    chk(1, 0, 1, 0); step(0, 0, 0);
    idle(4);
    tag = "gap_net0";
    chk(0, 1, 1, 0); step(0, 1, 1);
    chk(1, 1, 1, 0); step(0, 0, 0);
    idle(3);
    tag = "gap_last";
    chk(0, 1, 0, 0); step(0, 0, 1);
    chk(1, 1, 0, 0); step(0, 0, 0);
    idle(3);
    tag = "gap_from_empty";
    chk(0, 0, 0, 0); step(0, 1, 1);
    chk(1, 0, 0, 0); step(0, 0, 0);
    idle(3);
    tag = "to_idle";
    chk(0, 0, 0, 0); step(0, 0, 1);
    step(0, 0, 0);

    // Saturation, lost event, decrement at saturation.
    tag = "sat";
    chk(1, 1, 0, 0); step(0, 1, 0);
    chk(1, 0, 1, 0); step(0, 1, 0);
    chk(1, 1, 2, 0); step(0, 1, 0);
    chk(1, 0, 3, 0); step(0, 1, 0);
    tag = "lost";
    chk(1, 0, 3, 1); step(0, 1, 0);
    tag = "sat_release";
    chk(0, 1, 3, 1); step(0, 1, 1);
    chk(1, 1, 3, 1); step(0, 0, 0);

    // Reset mid-operation with in high during reset.
    tag = "mid_reset";
    chk(0, 0, 0, 0); step(1, 1, 1);
    chk(0, 0, 0, 0); step(0, 0, 0);

    idle(2);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations never checked, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/strobe_hold.md
# strobe_hold

Converts single-cycle strobes into a held level flag for slow or software-polled consumers, such as tracking-channel dump or accumulation-ready events read over the processor bus. Each accepted strobe also flips a toggle line, so a change-detecting strobe generator on the consumer side can regenerate exactly one pulse per event. The block queues strobes that arrive while the flag is held and releases them one per acknowledge. It sits between pulse-generating datapath logic and register/interrupt logic on the same clock.

## Interface
- HOLD_CYCLES, 4: minimum number of cycles `out` stays high per event (legal range ≥1).
- COUNT_WIDTH, 4: width of the pending-event counter.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  1  event strobe; each high cycle is one event.
- ack  input  1  consumer acknowledge; a single-cycle pulse or a held level is acceptable.
- out  output  1  held event flag.
- toggle  output  1  inverts once per accepted event.
- pending  output  COUNT_WIDTH  number of queued events not yet presented on `out`.
- overflow  output  1  sticky flag; set when an event is lost.

## Operation
- States: IDLE (`out`=0), HOLD (`out`=1, minimum-hold counter running), WAIT_ACK (`out`=1, minimum elapsed), GAP (`out`=0 for exactly one cycle between queued events).
- Reset values:
  - State IDLE.
  - `out`=0, `toggle`=0, `pending`=0, `overflow`=0.
  - Hold counter = 0.
  - Latched-ack bit = 0.
  - `in` and `ack` are ignored during reset cycles.
- Event acceptance:
  - Any cycle with `in`=1 and reset=0 is an event.
  - `toggle` inverts on the next edge for every event that is presented or queued. It does not invert for lost events.
- IDLE + event: go to HOLD, load the hold counter with HOLD_CYCLES-1, clear the latched-ack bit.
- HOLD behaviour:
  - The counter decrements each cycle.
  - `ack`=1 in HOLD sets the latched-ack bit.
  - When the counter is 0: go to WAIT_ACK, or release immediately if `ack` or the latched-ack bit is set.
- WAIT_ACK behaviour: `ack`=1 releases.
- Release:
  - If `pending`=0, go to IDLE.
  - If `pending`>0, go to GAP and decrement `pending`.
- GAP: always goes to HOLD on the next edge. The counter reloads and the latched-ack bit clears.
- Queuing:
  - An event in HOLD, WAIT_ACK or GAP increments `pending`.
  - An event in IDLE does not increment `pending`; it is presented directly.
- Simultaneous event and release-with-decrement: net change to `pending` is 0.
- Simultaneous event and release to IDLE (`pending`=0): the event is queued, so the next state is GAP, not IDLE. `out` falls for one cycle, then re-asserts.
- Saturation:
  - `pending` saturates at 2^COUNT_WIDTH-1.
  - An event arriving at saturation with no same-cycle decrement is lost and sets `overflow`.
  - `overflow` is cleared only by reset.
- Reset mid-operation: returns immediately to the reset values. Queued events are discarded.

## Timing
- Event at edge t: `out`=1 from t+1 and `toggle` flips at t+1.
- Minimum high time is HOLD_CYCLES cycles: `out` is high for cycles t+1 .. t+HOLD_CYCLES.
- Ack sampled at or before cycle t+HOLD_CYCLES: `out`=0 at t+HOLD_CYCLES+1.
- Ack sampled at cycle c > t+HOLD_CYCLES: `out`=0 at c+1.
- Queued event: `out` is low for one cycle (GAP), then high again. Its HOLD_CYCLES window starts on the re-assert cycle.
- `pending` and `overflow` update on the edge after the causing event.
- All outputs are registered; there is no combinational path from `in` or `ack` to any output.

## Test plan
- **Single event.** Reset, then `in`=1 at cycle 10, HOLD_CYCLES=4, no ack → `out` high from 11 and stays high; `toggle`=1 at 11; `pending`=0.
- **Early ack.** Event at 10, `ack` pulse at 12 → `out` high 11..14, low at 15; state IDLE.
- **Late ack.** Event at 10, `ack` at 20 → `out` low at 21.
- **Queuing with simultaneous event.**
  - Events at 10, 12, 13 → `pending`=2 at 14, `toggle` has flipped 3 times.
  - `ack` at 20 → `out` low at 21 (GAP), high at 22, `pending`=1.
  - `ack` at 26 together with `in`=1 → GAP at 27, `pending` remains 1.
- **Overflow.** COUNT_WIDTH=2: event, then 4 more events with no ack → `pending`=3 and `overflow`=1 after the 4th queued event. `toggle` flipped 4 times, not 5.
- **Reset mid-operation.** Apply reset with `pending`=2 and `out`=1, with `in`=1 during the reset cycle → all outputs 0 the next cycle; no event is recorded.
